// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: FSM states,
// register offsets and STATUS bit layout.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } tx_state_t;

   localparam logic [31:0] TXDATA_OFS = 32'd0;
   localparam logic [31:0] STATUS_OFS = 32'd4;

   localparam int STAT_BUSY    = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_EMPTY   = 2;
   localparam int STAT_OVF     = 3;
   localparam int STAT_CNT_LSB = 4;
   localparam int STAT_CNT_MSB = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered storage with combinational dout (show-ahead).
// A push while full is taken only when a pop frees the slot on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= din;
   end

   // Pointers wrap naturally since DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes a byte, STATUS reports state.
// tx falls one edge after a write into an idle, empty block; writes to a full FIFO are dropped and flagged.
module mmio_uart_tx
   import uart_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int          CLKS_PER_BIT = 868,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        rd_hit,
   output logic        tx
);

   localparam int          CW       = $clog2(FIFO_DEPTH) + 1;
   localparam logic [31:0] TX_ADDR  = BASE_ADDR + TXDATA_OFS;
   localparam logic [31:0] ST_ADDR  = BASE_ADDR + STATUS_OFS;
   localparam logic [15:0] RELOAD   = 16'(CLKS_PER_BIT - 1);

   tx_state_t   state;
   logic [15:0] bit_cnt;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        overflow;

   logic        tx_hit;
   logic        st_hit;
   logic        wr_tx;
   logic        wr_st;
   logic        bit_end;
   logic        fifo_pop;
   logic        fifo_full;
   logic        fifo_empty;
   logic [7:0]  fifo_dout;
   logic [CW-1:0] fifo_count;
   logic [31:0] status;
   logic        unused_bits;

   assign tx_hit   = (ALUResult[31:2] == TX_ADDR[31:2]);
   assign st_hit   = (ALUResult[31:2] == ST_ADDR[31:2]);
   assign wr_tx    = MemWrite & tx_hit & ~reset;
   assign wr_st    = MemWrite & st_hit & ~reset;
   assign bit_end  = (bit_cnt == 16'd0);
   assign fifo_pop = ~fifo_empty & ((state == S_IDLE) | ((state == S_STOP) & bit_end));
   assign unused_bits = ^{ALUResult[1:0], WriteData[31:8]};

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (wr_tx),
      .pop   (fifo_pop),
      .din   (WriteData[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         bit_cnt  <= 16'd0;
         bit_idx  <= 3'd0;
         shreg    <= 8'd0;
         overflow <= 1'b0;
      end else begin
         // A full-FIFO write is lost only if no pop frees a slot this edge.
         if (wr_tx & fifo_full & ~fifo_pop)
            overflow <= 1'b1;
         else if (wr_st & WriteData[STAT_OVF])
            overflow <= 1'b0;

         case (state)
            S_IDLE: begin
               if (fifo_pop) begin
                  shreg   <= fifo_dout;
                  tx      <= 1'b0;
                  bit_cnt <= RELOAD;
                  state   <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  tx      <= shreg[0];
                  bit_idx <= 3'd0;
                  bit_cnt <= RELOAD;
                  state   <= S_DATA;
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  bit_cnt <= RELOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shreg[bit_idx + 3'd1];
                  end
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  // Chain straight into the next start bit when more data waits.
                  if (fifo_pop) begin
                     shreg   <= fifo_dout;
                     tx      <= 1'b0;
                     bit_cnt <= RELOAD;
                     state   <= S_START;
                  end else begin
                     state <= S_IDLE;
                  end
               end else begin
                  bit_cnt <= bit_cnt - 16'd1;
               end
            end
            default: begin
               tx    <= 1'b1;
               state <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      status = 32'd0;
      status[STAT_BUSY]  = (state != S_IDLE);
      status[STAT_FULL]  = fifo_full;
      status[STAT_EMPTY] = fifo_empty;
      status[STAT_OVF]   = overflow;
      status[STAT_CNT_MSB:STAT_CNT_LSB] = 7'(fifo_count);
   end

   assign rd_hit   = tx_hit | st_hit;
   assign ReadData = rd_hit ? status : 32'd0;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed plus random checks of mmio_uart_tx against a frame-level reference model.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam logic [31:0] STA  = BASE + 32'd4;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemWrite;
   logic [31:0] ALUResult;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        rd_hit;
   logic        tx;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: byte queue plus position inside the frame being sent.
   logic [7:0] m_q[$];
   bit         m_active = 1'b0;
   int         m_pos    = 0;
   logic [7:0] m_cur    = 8'd0;
   bit         m_ovf    = 1'b0;

   mmio_uart_tx #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .MemWrite  (MemWrite),
      .ALUResult (ALUResult),
      .WriteData (WriteData),
      .ReadData  (ReadData),
      .rd_hit    (rd_hit),
      .tx        (tx)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic bit is_tx(input logic [31:0] a);
      return (a >> 2) == (BASE >> 2);
   endfunction

   function automatic bit is_st(input logic [31:0] a);
      return (a >> 2) == (STA >> 2);
   endfunction

   function automatic logic m_tx();
      int b;
      if (!m_active) return 1'b1;
      b = m_pos / CPB;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_status();
      int n;
      logic [31:0] s;
      n = m_q.size();
      s = 32'd0;
      s[0] = m_active;
      s[1] = (n == DEPTH);
      s[2] = (n == 0);
      s[3] = m_ovf;
      s[10:4] = 7'(n);
      return s;
   endfunction

   task automatic model_edge();
      if (reset) begin
         m_q.delete();
         m_active = 1'b0;
         m_pos    = 0;
         m_ovf    = 1'b0;
         return;
      end
      if (m_active) begin
         m_pos++;
         if (m_pos == FRAME) begin
            if (m_q.size() > 0) begin
               m_cur = m_q.pop_front();
               m_pos = 0;
            end else begin
               m_active = 1'b0;
            end
         end
      end else if (m_q.size() > 0) begin
         m_cur    = m_q.pop_front();
         m_active = 1'b1;
         m_pos    = 0;
      end
      if (MemWrite && is_tx(ALUResult)) begin
         if (m_q.size() < DEPTH) m_q.push_back(WriteData[7:0]);
         else m_ovf = 1'b1;
      end
      if (MemWrite && is_st(ALUResult) && WriteData[3]) m_ovf = 1'b0;
   endtask

   task automatic cyc();
      bit h;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      h = is_tx(ALUResult) || is_st(ALUResult);
      chk("tx", {31'd0, tx}, {31'd0, m_tx()});
      chk("rd_hit", {31'd0, rd_hit}, {31'd0, h});
      chk("ReadData", ReadData, h ? m_status() : 32'd0);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      MemWrite  = 1'b1;
      ALUResult = a;
      WriteData = d;
      cyc();
      MemWrite  = 1'b0;
      ALUResult = STA;
      WriteData = 32'd0;
   endtask

   task automatic drain();
      int g = 0;
      while ((m_active || m_q.size() > 0) && g < 3000) begin
         cyc();
         g++;
      end
      cyc();
      chk("drain_busy", {31'd0, ReadData[0]}, 32'd0);
   endtask

   initial begin
      logic [9:0] pat;
      int g;
      int r;
      pat       = 10'b10_1010_1010;
      reset     = 1'b1;
      MemWrite  = 1'b0;
      ALUResult = STA;
      WriteData = 32'd0;
      @(negedge clk);
      cyc();
      cyc();
      chk("reset_status", ReadData, 32'h4);
      chk("reset_tx", {31'd0, tx}, 32'd1);
      reset = 1'b0;
      cyc();

      // Scenario 1: single 0x55 frame, exact waveform
      wr(BASE, 32'h55);
      for (int i = 0; i < FRAME; i++) begin
         cyc();
         chk("s1_tx", {31'd0, tx}, {31'd0, pat[i/CPB]});
      end
      cyc();
      chk("s1_busy", {31'd0, ReadData[0]}, 32'd0);

      // Scenario 2: back-to-back frames
      wr(BASE, 32'hA3);
      wr(BASE, 32'h0F);
      drain();

      // Scenario 3: overflow from an idle start
      for (int k = 0; k < 6; k++) wr(BASE, $urandom);
      chk("s3_full", {31'd0, ReadData[1]}, 32'd1);
      chk("s3_count", {25'd0, ReadData[10:4]}, 32'd4);
      chk("s3_ovf", {31'd0, ReadData[3]}, 32'd1);
      wr(STA, 32'h8);
      chk("s3_ovf_clr", {31'd0, ReadData[3]}, 32'd0);

      // Scenario 4: full-FIFO write on the stop-end pop edge
      g = 0;
      while (!(m_active && m_pos == FRAME - 1 && m_q.size() > 0) && g < 200) begin
         cyc();
         g++;
      end
      wr(BASE, $urandom);
      chk("s4_count", {25'd0, ReadData[10:4]}, 32'd4);
      chk("s4_ovf", {31'd0, ReadData[3]}, 32'd0);
      drain();

      // Scenario 5: reset mid-frame, with a write in the reset cycle
      wr(BASE, $urandom);
      wr(BASE, $urandom);
      g = 0;
      while (!(m_active && m_pos == 15) && g < 200) begin
         cyc();
         g++;
      end
      reset     = 1'b1;
      MemWrite  = 1'b1;
      ALUResult = BASE;
      WriteData = $urandom;
      cyc();
      chk("s5_tx", {31'd0, tx}, 32'd1);
      chk("s5_status", ReadData, 32'h4);
      reset     = 1'b0;
      MemWrite  = 1'b0;
      ALUResult = STA;
      repeat (2 * FRAME) cyc();

      // Scenario 6: decode of bits [31:2] only
      MemWrite  = 1'b1;
      ALUResult = BASE + 32'd8;
      WriteData = 32'h5A;
      cyc();
      chk("s6_rdhit8", {31'd0, rd_hit}, 32'd0);
      chk("s6_rd8", ReadData, 32'd0);
      MemWrite  = 1'b0;
      ALUResult = BASE + 32'd3;
      cyc();
      chk("s6_rdhit3", {31'd0, rd_hit}, 32'd1);
      chk("s6_rd3", ReadData, 32'h4);
      ALUResult = STA;

      // Random traffic over nearby addresses
      repeat (200) begin
         r = $urandom_range(0, 9);
         if (r < 4) wr(BASE + 32'($urandom_range(0, 3)), $urandom);
         else if (r == 4) wr(STA + 32'($urandom_range(0, 3)), $urandom);
         else if (r == 5) wr(BASE + 32'($urandom_range(0, 15)), $urandom);
         else begin
            ALUResult = BASE - 32'd4 + 32'($urandom_range(0, 15));
            cyc();
            ALUResult = STA;
         end
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
